muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes on both sides.
//  It replaces single-cycle combinational MUL*/DIV*/REM* in the execute stage and stalls
//  the pipeline through in_ready/out_valid. Radix is set by UNROLL: bits resolved per clock.
// PARAMETERS
//  XLEN   32  operand/result width; must be a multiple of UNROLL
//  UNROLL 1   iteration steps per clock, one of 1, 2, 4; base latency = XLEN/UNROLL
//  TAG_W  5   width of the opaque tag (destination reg index) carried with each op
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  flush      in   1      abort in-flight op; no result is produced
//  in_valid   in   1      op request
//  in_ready   out  1      unit can accept a request this cycle
//  in_op      in   3      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  in_a       in   XLEN   rs1 operand
//  in_b       in   XLEN   rs2 operand
//  in_tag     in   TAG_W  passed through unchanged to out_tag
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes the result
//  out_result out  XLEN   result
//  out_tag    out  TAG_W  tag of the op that produced the result
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0.
//    in_ready=1 from the first cycle after reset. Reset mid-op discards the op with no output.
//  States:
//    IDLE: in_valid&in_ready -> BUSY. Special cases go directly to DONE.
//    BUSY: counter counts XLEN/UNROLL steps. Last step -> FIX (sign correction).
//    FIX:  -> DONE in one cycle.
//    DONE: out_valid=1. out_ready=1 -> IDLE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready & ~flush). This is combinational.
//    Accept on a retire cycle goes straight to BUSY (back-to-back ops).
//  Latency: accept edge to out_valid = XLEN/UNROLL + 2 cycles. Special cases take 1 cycle.
//  out_result and out_tag are held stable while out_valid=1 & out_ready=0.
//  flush: next state IDLE from BUSY, FIX or DONE. out_valid drops the next cycle.
//    flush overrides in_valid in the same cycle. flush in IDLE is a no-op.
//  Multiply:
//    Operands become magnitudes per signedness: MULH both signed, MULHSU a signed only,
//      MUL/MULHU unsigned.
//    Shift-add over XLEN steps gives a 2*XLEN product. Negate in FIX if the signs differ.
//    MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
//  Divide:
//    Restoring algorithm on magnitudes.
//    Quotient sign = sign(a)^sign(b); remainder sign = sign(a) (signed ops only).
//  Special cases (1-cycle, no iteration):
//    b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//    DIV with a==MIN, b==-1 -> MIN; REM of the same -> 0.
//  The counter never wraps. Unused in_op encodings cannot occur; the field is 3 bits.
// STRUCTURE
//  muldiv_pkg: op enum (funct3 order above), state enum {IDLE,BUSY,FIX,DONE},
//    function is_signed_a/is_signed_b(op).
//  Sub-module muldiv_step: combinational single step (shift-add or restore-subtract),
//    instanced UNROLL times in a chain inside muldiv_unit. No other hierarchy.
// TESTING (XLEN=32)
//  MUL 6*5, UNROLL=1 -> 30 with out_valid exactly 34 cycles after accept.
//    Repeat with UNROLL=4 -> 10 cycles.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF.
//  DIVU 6/5 -> 1. REMU 6/5 -> 1.
//  DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. Each 1-cycle latency.
//  Backpressure: hold out_ready=0 for 5 cycles -> result/tag stable, in_ready=0.
//    Raise out_ready with in_valid=1 -> new op accepted that cycle.
//  Flush on the 10th BUSY cycle -> no out_valid, in_ready=1 next cycle.
//    rst_n=0 mid-op -> all outputs at their reset values after the edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding (funct3 order),
// FSM states and operand-signedness helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StFix,
    StDone
  } state_e;

  function automatic logic is_signed_a(op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_b(op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step on the
// {hi, lo} working pair.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    addend  = lo[0] ? opnd : {XLEN{1'b0}};
    sum     = {1'b0, hi} + {1'b0, addend};
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      // Partial remainder stays below the divisor, so a borrow shows up in diff[XLEN].
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready on both sides.
// Resolves UNROLL bits per clock on magnitudes, then fixes the sign in one extra cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned     Steps   = XLEN / UNROLL;
  localparam int unsigned     CntW    = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);
  localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg_q, neg_d, neg_rem_q, neg_rem_d;

  op_e               in_op_e;
  logic              accept, is_div_in, neg_a, neg_b, b_zero, ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;

  assign in_op_e   = op_e'(in_op);
  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready & ~flush);
  assign accept    = in_valid & in_ready & ~flush;
  assign is_div_in = in_op[2];
  assign neg_a     = is_signed_a(in_op_e) & in_a[XLEN-1];
  assign neg_b     = is_signed_b(in_op_e) & in_b[XLEN-1];
  assign mag_a     = neg_a ? -in_a : in_a;
  assign mag_b     = neg_b ? -in_b : in_b;
  assign b_zero    = (in_b == '0);
  assign ovf       = ((in_op_e == OpDiv) | (in_op_e == OpRem)) & (in_a == MinVal) & (&in_b);
  assign special   = is_div_in & (b_zero | ovf);

  // in_op[1] separates REM/REMU from DIV/DIVU among the divide ops.
  always_comb begin
    if (b_zero) special_res = in_op[1] ? in_a : {XLEN{1'b1}};
    else        special_res = in_op[1] ? '0 : MinVal;
  end

  logic [XLEN-1:0] hi_c [UNROLL+1];
  logic [XLEN-1:0] lo_c [UNROLL+1];
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div  (op_q[2]),
      .hi      (hi_c[u]),
      .lo      (lo_c[u]),
      .opnd    (opnd_q),
      .hi_next (hi_c[u+1]),
      .lo_next (lo_c[u+1])
    );
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    unique case (op_q)
      OpMul:                     fix_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_res = quo_fix;
      default:                   fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      StBusy: begin
        hi_d = hi_c[UNROLL];
        lo_d = lo_c[UNROLL];
        if (cnt_q == LastCnt) state_d = StFix;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone:  if (out_ready) state_d = StIdle;
      default: ;
    endcase
    if (flush) state_d = StIdle;
    if (accept) begin
      op_d      = in_op_e;
      tag_d     = in_tag;
      cnt_d     = '0;
      neg_d     = neg_a ^ neg_b;
      neg_rem_d = neg_a;
      if (special) begin
        result_d = special_res;
        state_d  = StDone;
      end else begin
        state_d = StBusy;
        hi_d    = '0;
        lo_d    = is_div_in ? mag_a : mag_b;
        opnd_d  = is_div_in ? mag_b : mag_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: UNROLL=1 main instance plus an UNROLL=4 instance
// used for the radix-4 latency case.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid4 = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid, busy;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_result, out_result4;
  logic [4:0]  out_tag, out_tag4;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4), .TAG_W(5)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .out_result (out_result4),
    .out_tag    (out_tag4),
    .busy       (busy4)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single cycle; expects it to be accepted on that edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, input logic push,
                       input logic [31:0] exp_res);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tg;
    in_valid = 1'b1;
    #1;
    check_eq({name, "_in_ready"}, in_ready, 1'b1);
    if (push) sb_q.push_back('{res: exp_res, tag: tg});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat, output logic ok);
    int lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    ok = out_valid;
    if (!ok) check_eq({name, "_timeout"}, out_valid, 1'b1);
    else     check_eq({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic compare_front(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({name, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check_eq({name, "_result"}, out_result, e.res);
      check_eq({name, "_tag"}, out_tag, e.tag);
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp_res,
                        input int exp_lat);
    logic ok;
    issue(name, op, a, b, tg, 1'b1, exp_res);
    wait_valid(name, exp_lat, ok);
    if (ok) compare_front(name);
    else if (sb_q.size() > 0) void'(sb_q.pop_front());
    retire();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   lat;
    int   spurious;

    vecs[0]  = '{3'd0, 32'd6,        32'd5,        32'd30,       34};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'd5, 32'd6,        32'd5,        32'd1,        34};
    vecs[7]  = '{3'd7, 32'd6,        32'd5,        32'd1,        34};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'd4, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34};
    vecs[13] = '{3'd6, 32'd100,      32'hFFFFFFF9, 32'd2,        34};
    vecs[14] = '{3'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 34};

    tick();
    tick();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_out_tag", out_tag, 5'd0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
             vecs[i].res, vecs[i].lat);
    end

    // Radix-4 instance: same MUL, shorter latency.
    in_op     = 3'd0;
    in_a      = 32'd6;
    in_b      = 32'd5;
    in_tag    = 5'd12;
    in_valid4 = 1'b1;
    #1;
    check_eq("u4_in_ready", in_ready4, 1'b1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 200) begin
      tick();
      lat++;
    end
    check_eq("u4_latency", lat, 10);
    check_eq("u4_result", out_result4, 32'd30);
    check_eq("u4_tag", out_tag4, 5'd12);
    retire();

    // Backpressure: result held, then retire and accept in the same cycle.
    issue("bp", 3'd0, 32'd7, 32'd9, 5'd21, 1'b1, 32'd63);
    wait_valid("bp", 34, ok);
    if (ok) begin
      for (int c = 0; c < 5; c++) begin
        check_eq("bp_hold_result", out_result, sb_q[0].res);
        check_eq("bp_hold_tag", out_tag, sb_q[0].tag);
        check_eq("bp_hold_in_ready", in_ready, 1'b0);
        check_eq("bp_hold_valid", out_valid, 1'b1);
        tick();
      end
      compare_front("bp");
    end else if (sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    out_ready = 1'b1;
    issue("bp_next", 3'd5, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14);
    out_ready = 1'b0;
    wait_valid("bp_next", 34, ok);
    if (ok) compare_front("bp_next");
    else if (sb_q.size() > 0) void'(sb_q.pop_front());
    retire();

    // Flush on the 10th BUSY cycle.
    issue("fl", 3'd4, 32'd1000, 32'd3, 5'd9, 1'b0, 32'd0);
    for (int c = 1; c < 10; c++) tick();
    check_eq("fl_busy_before", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_out_valid", out_valid, 1'b0);
    check_eq("fl_in_ready", in_ready, 1'b1);
    check_eq("fl_busy", busy, 1'b0);
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) spurious++;
      tick();
    end
    check_eq("fl_no_result", spurious, 0);

    // Reset in the middle of an op.
    issue("rs", 3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd17, 1'b0, 32'd0);
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    check_eq("rs_out_valid", out_valid, 1'b0);
    check_eq("rs_out_result", out_result, 32'd0);
    check_eq("rs_out_tag", out_tag, 5'd0);
    check_eq("rs_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("rs_in_ready", in_ready, 1'b1);
    spurious = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) spurious++;
      tick();
    end
    check_eq("rs_no_result", spurious, 0);

    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
